// File: rtl/watch_cfg_ctrl_if.sv
// Wishbone slave bus bundle for watch_cfg_ctrl; signal names follow the caravel wbs_* convention.
interface watch_cfg_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/watch_cfg_ctrl.sv
// Wishbone-controlled sequencer for asic_watch time-set loads: stage HH:MM, commit,
// range-check, then pulse dvalid_o/cfg_o for LOAD_CYCLES cycles with status readback.
module watch_cfg_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFF0,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               sysclk_i,
  input  logic               rstn_i,
  watch_cfg_ctrl_if.slave    wb,
  output logic               dvalid_o,
  output logic [11:0]        cfg_o,
  output logic               busy_o
);

  localparam int unsigned LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, LOAD} state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [10:0]      stage_q, stage_d;
  logic [10:0]      cfg_q, cfg_d;
  logic             err_q, err_d, ovr_q, ovr_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LCW-1:0]   lc_q, lc_d;

  logic        hit, acc, wr, commit, clr, busy;
  logic [1:0]  rsel;
  logic [31:0] rdata, status;
  logic        unused_bits;

  assign hit  = (wb.wbs_adr_i & ADDR_MASK) == ADDR_BASE;
  // acc only in cycles where ack is low, so a held request is acked every other cycle
  assign acc  = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
  assign wr   = acc & wb.wbs_we_i;
  assign rsel = wb.wbs_adr_i[3:2];
  assign busy = (state_q != IDLE);

  assign commit = wr && (rsel == 2'd1) && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
  assign clr    = wr && (rsel == 2'd1) && wb.wbs_sel_i[0] && wb.wbs_dat_i[1];

  assign status = (32'(cnt_q) << 8) | {28'b0, done_q, ovr_q, err_q, busy};

  assign unused_bits = ^{wb.wbs_dat_i[31:11], wb.wbs_sel_i[3:2]};

  always_comb begin
    rdata = '0;
    case (rsel)
      2'd0:    rdata = {21'b0, stage_q};
      2'd2:    rdata = status;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ack_d   = acc;
    dat_d   = (acc & ~wb.wbs_we_i) ? rdata : '0;
    stage_d = stage_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    lc_d    = lc_q;

    if (wr && rsel == 2'd0) begin
      if (wb.wbs_sel_i[0]) stage_d[7:0]  = wb.wbs_dat_i[7:0];
      if (wb.wbs_sel_i[1]) stage_d[10:8] = wb.wbs_dat_i[10:8];
    end

    // clear first so any flag set below in the same cycle survives
    if (clr) begin
      err_d  = 1'b0;
      ovr_d  = 1'b0;
      done_d = 1'b0;
    end

    if (commit && busy) ovr_d = 1'b1;

    case (state_q)
      IDLE: if (commit) state_d = CHECK;
      CHECK: begin
        if (stage_q[10:6] <= 5'd23 && stage_q[5:0] <= 6'd59) begin
          state_d = LOAD;
          cfg_d   = stage_q;
          lc_d    = LCW'(LOAD_CYCLES - 1);
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      LOAD: begin
        if (lc_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          lc_d = lc_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      stage_q <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      stage_q <= stage_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign dvalid_o     = (state_q == LOAD);
  assign busy_o       = busy;
  assign cfg_o        = {1'b0, cfg_q};

endmodule
